// File: rtl/isqrt_seq.sv
// isqrt_seq -- sequential integer square root (digit-by-digit, MSB first).
//
// Computes root = floor(sqrt(x)) and rem = x - root^2 for an unsigned
// WIDTH-bit operand, resolving BITS_PER_CYCLE root bits per clock, so one
// operation takes N = WIDTH/(2*BITS_PER_CYCLE) cycles in CALC.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand x valid            in_ready   high only in IDLE
//   x          unsigned operand (WIDTH)
//   out_valid  result valid (DONE)        out_ready  downstream accepts result
//   root       square root (WIDTH/2)      rem        floor remainder (WIDTH/2+1)
//   exact      x is a perfect square      busy       high in CALC and DONE
//
// Optional feature macro: ISQRT_ROUND_EN
//   defined   : root is rounded to nearest (floor_root+1 when rem > floor_root),
//               saturating at all-ones; rem/exact still describe the floor result.
//   undefined : root is the floor root.
//
// States:
//   S_IDLE | waiting for an operand, in_ready high
//   S_CALC | iterating, BITS_PER_CYCLE root bits per cycle
//   S_DONE | result presented, waiting for out_ready

module isqrt_seq #(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH/2-1:0] root,
    output logic [WIDTH/2:0]   rem,
    output logic               exact,
    output logic               busy
);

    localparam int H  = WIDTH / 2;
    localparam int N  = WIDTH / (2 * BITS_PER_CYCLE);
    localparam int CW = $clog2(N) + 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [H-1:0]  ROOT_ONE = H'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] x_q, x_d;
    logic [H+1:0]     rem_part_q, rem_part_d;
    logic [H-1:0]     root_part_q, root_part_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [H-1:0]     root_q, root_d;
    logic [H:0]       rem_q, rem_d;
    logic             exact_q, exact_d;

    logic             last_iter;

    // One iteration: BITS_PER_CYCLE unrolled restoring steps. The working
    // remainder is H+2 bits so that (rem << 2 | pair) never overflows
    // before the trial subtraction.
    logic [H+1:0]     rem_w;
    logic [H+1:0]     trial_w;
    logic [H-1:0]     root_w;
    logic [WIDTH-1:0] xs_w;
    logic [H-1:0]     root_fin;

    always_comb begin
        rem_w   = rem_part_q;
        root_w  = root_part_q;
        xs_w    = x_q;
        trial_w = '0;
        for (int b = 0; b < BITS_PER_CYCLE; b++) begin
            rem_w   = {rem_w[H-1:0], xs_w[WIDTH-1 -: 2]};
            xs_w    = {xs_w[WIDTH-3:0], 2'b00};
            trial_w = {root_w, 2'b01};
            if (rem_w >= trial_w) begin
                rem_w  = rem_w - trial_w;
                root_w = {root_w[H-2:0], 1'b1};
            end else begin
                root_w = {root_w[H-2:0], 1'b0};
            end
        end
    end

`ifdef ISQRT_ROUND_EN
    // rem > root means x >= root^2 + root + 1, i.e. sqrt(x) > root + 0.5.
    always_comb begin
        root_fin = root_w;
        if ((rem_w[H:0] > {1'b0, root_w}) && (root_w != '1)) begin
            root_fin = root_w + ROOT_ONE;
        end
    end
`else
    assign root_fin = root_w;
`endif

    assign last_iter = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_CALC;
            S_CALC:  if (last_iter) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the state register only
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_CALC) || (state_q == S_DONE);
    end

    // Datapath next-state
    always_comb begin
        x_d         = x_q;
        rem_part_d  = rem_part_q;
        root_part_d = root_part_q;
        cnt_d       = cnt_q;
        root_d      = root_q;
        rem_d       = rem_q;
        exact_d     = exact_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d         = x;
                    rem_part_d  = '0;
                    root_part_d = '0;
                    cnt_d       = '0;
                end
            end
            S_CALC: begin
                x_d         = xs_w;
                rem_part_d  = rem_w;
                root_part_d = root_w;
                cnt_d       = cnt_q + CNT_ONE;
                if (last_iter) begin
                    root_d  = root_fin;
                    rem_d   = rem_w[H:0];
                    exact_d = (rem_w == '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q         <= '0;
            rem_part_q  <= '0;
            root_part_q <= '0;
            cnt_q       <= '0;
            root_q      <= '0;
            rem_q       <= '0;
            exact_q     <= 1'b0;
        end else begin
            x_q         <= x_d;
            rem_part_q  <= rem_part_d;
            root_part_q <= root_part_d;
            cnt_q       <= cnt_d;
            root_q      <= root_d;
            rem_q       <= rem_d;
            exact_q     <= exact_d;
        end
    end

    assign root  = root_q;
    assign rem   = rem_q;
    assign exact = exact_q;

endmodule

// File: tb/tb_isqrt_seq.sv
module tb_isqrt_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Unit 0: WIDTH=64, BITS_PER_CYCLE=1. Unit 1: WIDTH=64, BITS_PER_CYCLE=2.
    logic        in_valid_s  [2];
    logic        in_ready_s  [2];
    logic [63:0] x_s         [2];
    logic        out_valid_s [2];
    logic        out_ready_s [2];
    logic [31:0] root_s      [2];
    logic [32:0] rem_s       [2];
    logic        exact_s     [2];
    logic        busy_s      [2];

    isqrt_seq #(.WIDTH(64), .BITS_PER_CYCLE(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .x(x_s[0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
        .root(root_s[0]), .rem(rem_s[0]), .exact(exact_s[0]), .busy(busy_s[0])
    );

    isqrt_seq #(.WIDTH(64), .BITS_PER_CYCLE(2)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .x(x_s[1]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
        .root(root_s[1]), .rem(rem_s[1]), .exact(exact_s[1]), .busy(busy_s[1])
    );

    typedef struct {
        int          u;
        logic [63:0] x;
        logic [31:0] root;
        logic [32:0] rem;
        logic        exact;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Hand-computed vectors: x, floor root, rounded root, remainder, exact.
    localparam int NV = 15;
    logic [63:0] vx   [NV] = '{64'd144, 64'd10, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd49,
                               64'd13, 64'd12, 64'd1, 64'd2, 64'd3,
                               64'h4000_0000_0000_0000, 64'hFFFF_FFFE_0000_0001, 64'd99,
                               64'd1000000, 64'hFFFF_FFFE_0000_0000};
    logic [31:0] vrf  [NV] = '{32'd12, 32'd3, 32'd0, 32'hFFFF_FFFF, 32'd7,
                               32'd3, 32'd3, 32'd1, 32'd1, 32'd1,
                               32'h8000_0000, 32'hFFFF_FFFF, 32'd9,
                               32'd1000, 32'hFFFF_FFFE};
    logic [31:0] vrr  [NV] = '{32'd12, 32'd3, 32'd0, 32'hFFFF_FFFF, 32'd7,
                               32'd4, 32'd3, 32'd1, 32'd1, 32'd2,
                               32'h8000_0000, 32'hFFFF_FFFF, 32'd10,
                               32'd1000, 32'hFFFF_FFFF};
    logic [32:0] vrem [NV] = '{33'd0, 33'd1, 33'd0, 33'h1_FFFF_FFFE, 33'd0,
                               33'd4, 33'd3, 33'd0, 33'd1, 33'd2,
                               33'd0, 33'd0, 33'd18,
                               33'd0, 33'h1_FFFF_FFFC};
    logic        vex  [NV] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                               1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                               1'b1, 1'b1, 1'b0,
                               1'b1, 1'b0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                if (!rst && out_valid_s[u] && out_ready_s[u]) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 64'(u), 64'(99));
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("unit x=%0h", e.x), 64'(u), 64'(e.u));
                        chk($sformatf("root x=%0h", e.x), 64'(root_s[u]), 64'(e.root));
                        chk($sformatf("rem x=%0h", e.x), 64'(rem_s[u]), 64'(e.rem));
                        chk($sformatf("exact x=%0h", e.x), 64'(exact_s[u]), 64'(e.exact));
                    end
                end
            end
        end
    endtask

    // Called #1 after a rising edge with unit u idle.
    task automatic run_op(input int u, input int i, input bit bp, input bit spur);
        exp_t e;
        int   lat;
        int   n_exp;
        n_exp = (u == 0) ? 32 : 16;
        e.u = u;
        e.x = vx[i];
`ifdef ISQRT_ROUND_EN
        e.root = vrr[i];
`else
        e.root = vrf[i];
`endif
        e.rem   = vrem[i];
        e.exact = vex[i];
        chk("idle_in_ready", 64'(in_ready_s[u]), 64'(1));
        sb.push_back(e);
        x_s[u]         = vx[i];
        in_valid_s[u]  = 1'b1;
        out_ready_s[u] = !bp;
        @(posedge clk); #1;
        in_valid_s[u] = 1'b0;
        x_s[u]        = '0;
        chk("calc_busy_inready_valid", 64'({busy_s[u], in_ready_s[u], out_valid_s[u]}), 64'(3'b100));
        lat = 0;
        while (!out_valid_s[u] && lat < 200) begin
            if (spur && lat < 4) begin
                in_valid_s[u] = 1'b1;
                x_s[u]        = 64'd12345;
            end else begin
                in_valid_s[u] = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid_s[u] = 1'b0;
        chk("latency", 64'(lat), 64'(n_exp));
        if (bp) begin
            for (int c = 0; c < 10; c++) begin
                in_valid_s[u] = 1'b1;
                x_s[u]        = 64'd777;
                chk("bp_flags", 64'({out_valid_s[u], in_ready_s[u], busy_s[u]}), 64'(3'b101));
                chk("bp_root", 64'(root_s[u]), 64'(e.root));
                chk("bp_rem", 64'(rem_s[u]), 64'(e.rem));
                @(posedge clk); #1;
            end
            in_valid_s[u]  = 1'b0;
            out_ready_s[u] = 1'b1;
        end
        @(posedge clk); #1;
        chk("after_consume_flags", 64'({out_valid_s[u], in_ready_s[u], busy_s[u]}), 64'(3'b010));
        chk("after_consume_root_held", 64'(root_s[u]), 64'(e.root));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            in_valid_s[u]  = 1'b0;
            x_s[u]         = '0;
            out_ready_s[u] = 1'b0;
        end
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", 64'({in_ready_s[0], out_valid_s[0], busy_s[0]}), 64'(3'b100));
        chk("rst_root", 64'(root_s[0]), 64'(0));
        chk("rst_rem", 64'(rem_s[0]), 64'(0));
        chk("rst_exact", 64'(exact_s[0]), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(0, 0, 1'b0, 1'b0);
        run_op(0, 1, 1'b0, 1'b1);
        run_op(0, 2, 1'b0, 1'b0);
        run_op(0, 3, 1'b0, 1'b0);
        run_op(0, 12, 1'b1, 1'b0);
        for (int i = 5; i < NV; i++) begin
            if (i != 12) run_op(0, i, 1'b0, 1'b0);
        end

        // Abort an operation with reset five cycles into CALC.
        x_s[0]        = 64'd1000000;
        in_valid_s[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_s[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_flags", 64'({out_valid_s[0], in_ready_s[0]}), 64'(2'b01));
        chk("abort_root", 64'(root_s[0]), 64'(0));
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            seen = seen | out_valid_s[0];
        end
        chk("no_valid_after_rst", 64'(seen), 64'(0));
        run_op(0, 4, 1'b0, 1'b0);

        for (int i = 0; i < NV; i++) run_op(1, i, (i == 5), 1'b0);

        repeat (3) @(posedge clk);
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
